// File: rtl/if_stream_tagger.sv
// if_stream_tagger
//
// Staging buffer for input-feature (IF) words. It sits directly upstream of
// the PE datapath. Raw IF words arrive from the global-buffer stream over a
// valid/ready handshake. Each accepted word is tagged with row-start and
// row-end flags, based on a configurable row length. The tagged words are
// queued in a first-word-fall-through FIFO that the PE drains.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   cfg_ld       load cfg_row_len and restart column counting
//   cfg_row_len  words per IF row (0 is treated as 1)
//   in_valid     upstream word valid
//   in_data      upstream IF word
//   in_ready     block can accept a word this cycle
//   buf_read     PE pops the head entry
//   buf_out      head entry {start, end, data}; all zeros when empty
//   buf_empty    FIFO holds no entries
//   buf_full     FIFO holds DEPTH entries
//   count        current occupancy
//   rows_pushed  complete rows accepted since reset or cfg_ld (wraps)
module if_stream_tagger #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int PTR_LEN       = 3,
  parameter int ROW_LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_ld,
  input  logic [ROW_LEN_WIDTH-1:0] cfg_row_len,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic                     buf_read,
  output logic [DATA_WIDTH+1:0]    buf_out,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic [PTR_LEN:0]         count,
  output logic [ROW_LEN_WIDTH-1:0] rows_pushed
);

  logic [DATA_WIDTH+1:0]    mem [DEPTH];
  logic [PTR_LEN-1:0]       rptr;
  logic [PTR_LEN-1:0]       wptr;
  logic [ROW_LEN_WIDTH-1:0] col;
  logic [ROW_LEN_WIDTH-1:0] row_len_reg;

  logic push;
  logic pop;
  logic tag_start;
  logic tag_end;

  // The status flags come straight from the occupancy counter. Input is
  // refused during a cfg_ld cycle, so a word is never tagged against a
  // row length that is being replaced.
  assign buf_empty = (count == '0);
  assign buf_full  = (count == (PTR_LEN+1)'(DEPTH));
  assign in_ready  = !buf_full && !cfg_ld;

  // A pop on an empty FIFO is dropped. A push on a full FIFO cannot happen
  // because in_ready is already low.
  assign push = in_valid && in_ready;
  assign pop  = buf_read && !buf_empty;

  // Row flags depend only on the column position of the word being accepted.
  assign tag_start = (col == '0);
  assign tag_end   = (col == row_len_reg - ROW_LEN_WIDTH'(1));

  // FWFT head. The output is forced to zero when empty, so stale storage
  // contents are never presented to the PE.
  assign buf_out = buf_empty ? '0 : mem[rptr];

  // Storage is not reset. Writes are suppressed during reset so that a
  // stale in_ready cannot deposit a word that the reset is discarding.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr] <= {tag_start, tag_end, in_data};
    end
  end

  // Pointers, occupancy, column tracking and the row counter. cfg_ld only
  // restarts tagging. Entries already queued keep their tags, and a
  // concurrent pop still drains normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      col         <= '0;
      rows_pushed <= '0;
      row_len_reg <= ROW_LEN_WIDTH'(1);
    end else begin
      if (cfg_ld) begin
        col         <= '0;
        rows_pushed <= '0;
        row_len_reg <= (cfg_row_len == '0) ? ROW_LEN_WIDTH'(1) : cfg_row_len;
      end else if (push) begin
        if (tag_end) begin
          col         <= '0;
          rows_pushed <= rows_pushed + ROW_LEN_WIDTH'(1);
        end else begin
          col <= col + ROW_LEN_WIDTH'(1);
        end
      end

      if (push) begin
        wptr <= wptr + PTR_LEN'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_LEN'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + (PTR_LEN+1)'(1);
        2'b01:   count <= count - (PTR_LEN+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stream_tagger.sv
// Testbench for if_stream_tagger.
//
// The reference model is a queue of tagged words plus a count of words
// accepted since the last cfg_ld. Row flags and the row count are derived
// from that count with modulo/divide arithmetic.
module tb_if_stream_tagger;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_ld;
  logic [7:0]    cfg_row_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          buf_read;
  logic [DW+1:0] buf_out;
  logic          buf_empty;
  logic          buf_full;
  logic [3:0]    count;
  logic [7:0]    rows_pushed;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [DW+1:0] model_q[$];
  int            model_len = 1;
  int            model_accepted = 0;

  if_stream_tagger #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_LEN(3), .ROW_LEN_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ld(cfg_ld), .cfg_row_len(cfg_row_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .buf_read(buf_read), .buf_out(buf_out), .buf_empty(buf_empty),
    .buf_full(buf_full), .count(count), .rows_pushed(rows_pushed)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Drive the inputs, then compare every output against the
  // model at the falling edge. Then advance the model by the transfer the
  // rules say happens at the rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic [7:0] len,
                               input logic v, input logic [DW-1:0] d, input logic rd);
    bit do_push, do_pop;
    int pos;
    rst = r; cfg_ld = c; cfg_row_len = len; in_valid = v; in_data = d; buf_read = rd;
    @(negedge clk);
    checkOutput("buf_empty", 32'(buf_empty), 32'(model_q.size() == 0));
    checkOutput("buf_full", 32'(buf_full), 32'(model_q.size() == DEPTH));
    checkOutput("count", 32'(count), 32'(model_q.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH && !c));
    checkOutput("buf_out", 32'(buf_out), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
    checkOutput("rows_pushed", 32'(rows_pushed), (model_accepted / model_len) % 256);
    if (r) begin
      model_q.delete();
      model_len = 1;
      model_accepted = 0;
    end else begin
      do_push = v && !c && (model_q.size() < DEPTH);
      do_pop  = rd && (model_q.size() != 0);
      if (c) begin
        model_len = (len == 0) ? 1 : int'(len);
        model_accepted = 0;
      end
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        pos = model_accepted % model_len;
        model_q.push_back({pos == 0, pos == model_len - 1, d});
        model_accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++)
      applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  logic [DW+1:0] row_seq [7] = '{10'h210, 10'h011, 10'h112, 10'h213, 10'h014, 10'h115, 10'h216};

  initial begin
    rst = 1; cfg_ld = 0; cfg_row_len = 0; in_valid = 0; in_data = 0; buf_read = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset check");
    idle(2);

    $display("[TB] row tagging, length 3");
    applyStimulus(0, 1, 8'd3, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 8'(8'h10 + i), 0);
    checkOutput("rows_after_row_test", 32'(rows_pushed), 32'd2);
    for (int i = 0; i < 7; i++) begin
      checkOutput("row_seq", 32'(buf_out), 32'(row_seq[i]));
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    idle(1);

    $display("[TB] full and backpressure");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 1, 8'(8'h40 + i), 0);
    checkOutput("full_count", 32'(count), 32'd8);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 0, 1, 8'h48, 1);
    applyStimulus(0, 0, 0, 1, 8'h48, 0);
    drain();

    $display("[TB] simultaneous push and pop");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 8'(8'h70 + i), 1);
    checkOutput("pushpop_count", 32'(count), 32'd4);
    drain();
    applyStimulus(0, 0, 0, 1, 8'h5A, 1);
    checkOutput("empty_pushpop_count", 32'(count), 32'd1);
    drain();

    $display("[TB] degenerate row lengths");
    for (int l = 0; l < 2; l++) begin
      applyStimulus(0, 1, 8'(l), 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 8'hAA, 0);
      applyStimulus(0, 0, 0, 1, 8'hBB, 0);
      checkOutput("degen_rows", 32'(rows_pushed), 32'd2);
      checkOutput("degen_head", 32'(buf_out), 32'h3AA);
      drain();
    end

    $display("[TB] cfg_ld and reset mid-operation");
    applyStimulus(0, 1, 8'd2, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'(8'h80 + i), 0);
    applyStimulus(0, 1, 8'd3, 1, 8'hEE, 0);
    applyStimulus(0, 0, 0, 1, 8'h90, 0);
    applyStimulus(0, 0, 0, 1, 8'h91, 0);
    checkOutput("mid_cfg_count", 32'(count), 32'd5);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("mid_rst_empty", 32'(buf_empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("mid_rst_count", 32'(count), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 39) == 0),
                    8'($urandom_range(0, 5)), ($urandom_range(0, 9) < 7),
                    8'($urandom), ($urandom_range(0, 9) < 6));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stream_tagger.md
Name: if_stream_tagger

Overview:
- Input-feature (IF) staging buffer that sits directly upstream of the PE datapath.
- Accepts raw IF words from the global-buffer stream over a valid/ready handshake.
- Tags each word with row-start and row-end flags from a configurable row length, then queues the tagged words in a first-word-fall-through FIFO.
- Drives the PE's IF buffer input word, IF buffer empty flag and IF buffer read strobe interface.

Parameters:
- DATA_WIDTH, 8, IF word width (equals IF_SCRATCH_WIDTH of the PE).
- DEPTH, 8, FIFO entries; power of two.
- PTR_LEN, 3, log2(DEPTH).
- ROW_LEN_WIDTH, 8, width of the row-length configuration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_ld  in  1  load cfg_row_len and restart column counting.
- cfg_row_len  in  ROW_LEN_WIDTH  words per IF row.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_WIDTH  upstream IF word.
- in_ready  out  1  block can accept a word this cycle.
- buf_read  in  1  PE pops the head entry.
- buf_out  out  DATA_WIDTH+2  head entry: [DATA_WIDTH+1] = start flag, [DATA_WIDTH] = end flag, [DATA_WIDTH-1:0] = data.
- buf_empty  out  1  FIFO holds no entries.
- buf_full  out  1  FIFO holds DEPTH entries.
- count  out  PTR_LEN+1  current occupancy.
- rows_pushed  out  ROW_LEN_WIDTH  number of complete rows accepted since reset or cfg_ld; wraps.

Behaviour:
- All state updates happen on the rising edge of clk.
- rst (synchronous, active-high) has highest priority:
  - rptr = wptr = 0, count = 0, col = 0, rows_pushed = 0, row_len_reg = 1.
  - Resulting outputs: buf_empty = 1, buf_full = 0, in_ready = 1.
  - Storage array is not reset.
  - Reset mid-transfer discards all queued entries and any partial row.
- buf_out = mem[rptr] when !buf_empty, else all zeros. It is combinational (FWFT): the head is visible in the same cycle the PE samples it.
- in_ready = !buf_full && !cfg_ld. A word is accepted iff in_valid && in_ready.
- cfg_ld cycle: col <= 0, rows_pushed <= 0.
  - row_len_reg <= cfg_row_len, or 1 if cfg_row_len == 0.
  - No word is accepted that cycle. Queued entries keep their existing tags.
- Tagging of each accepted word:
  - start = (col == 0).
  - end = (col == row_len_reg - 1).
  - If end: col <= 0 and rows_pushed <= rows_pushed + 1 (wraps). Otherwise col <= col + 1.
  - With row_len_reg == 1, every word carries both start and end.
- Pop:
  - buf_read && !buf_empty: rptr <= rptr + 1 (mod DEPTH).
  - buf_read while empty is ignored; no pointer or count change.
- Push: an accepted word is written to mem[wptr] and wptr <= wptr + 1 (mod DEPTH). Pointers wrap naturally at DEPTH.
- Simultaneous push and pop:
  - Non-empty: both occur; count unchanged.
  - Empty: push only; the pop is ignored and the new entry appears on buf_out next cycle.
  - Full: in_ready = 0, so pop only.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- buf_empty = (count == 0); buf_full = (count == DEPTH).
- Latency: an accepted word is visible on buf_out one cycle after acceptance if the FIFO was empty.
- Throughput: 1 word per cycle in and out sustained.

Test Plan:
- Reset check: assert rst 2 cycles -> buf_empty = 1, buf_full = 0, count = 0, in_ready = 1, buf_out = 0, rows_pushed = 0.
- Row tagging: cfg_ld with row_len = 3, push 0x10..0x16, then drain -> buf_out sequence is 0x210, 0x011, 0x112, 0x213, 0x014, 0x115, 0x216; rows_pushed = 2.
- Full/backpressure: push 9 words with no reads, DEPTH = 8 -> in_ready drops after the 8th; count = 8; the 9th word is held until one buf_read, then accepted; data order is preserved across pointer wrap.
- Simultaneous push/pop: 4 entries queued, in_valid and buf_read held for 10 cycles -> count stays 4 and output order is FIFO-correct. From empty, push plus read in the same cycle -> count = 1 and the read is ignored.
- Degenerate lengths: cfg_row_len = 0 and 1, push 0xAA, 0xBB -> both entries have start = end = 1 (0x3AA, 0x3BB); rows_pushed = 2.
- Mid-operation events:
  - cfg_ld while 3 entries queued and col = 1 -> queued tags unchanged; the next accepted word carries start = 1; in_ready = 0 during the cfg_ld cycle.
  - rst asserted while 5 entries queued -> buf_empty = 1 the next cycle; a read that cycle is ignored.
